// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter
//  Purpose  : Shares one combinational 32-bit ALU between two requesters.
//             Round-robin arbitration picks a requester and registers its
//             operands, which then drive the ALU. The ALU result (or an
//             illegal-select error) is captured and returned on a
//             valid/ready response channel tagged with the requester ID.
//             One operation is in flight at a time (IDLE -> EXEC -> RESP).
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, reset                 clock (rising edge), async active-high reset
//    reqN_valid / reqN_ready    request handshake for requester N (0/1)
//    reqN_op1, reqN_op2         operands
//    reqN_shamt                 shift amount
//    reqN_select                ALU op: 000 add, 001 sub, 010 and, 011 or,
//                               100 shl, 101 shr, 110/111 illegal
//    resp_valid / resp_ready    response handshake
//    resp_id                    requester that issued the response
//    resp_result, resp_err      ALU result / illegal-select flag
//    alu_operand1/2, alu_shamt, alu_select   to the external ALU
//    alu_result                 from the external ALU
// ============================================================================
module alu_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_op1,
    input  logic [DATA_W-1:0] req0_op2,
    input  logic [4:0]        req0_shamt,
    input  logic [2:0]        req0_select,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_op1,
    input  logic [DATA_W-1:0] req1_op2,
    input  logic [4:0]        req1_shamt,
    input  logic [2:0]        req1_select,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_result,
    output logic              resp_err,
    output logic [DATA_W-1:0] alu_operand1,
    output logic [DATA_W-1:0] alu_operand2,
    output logic [4:0]        alu_shamt,
    output logic [2:0]        alu_select,
    input  logic [DATA_W-1:0] alu_result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              ptr;          // requester that wins a tie
    logic              any_valid;
    logic              grant_id;
    logic              handshake;
    logic [DATA_W-1:0] op1_reg;
    logic [DATA_W-1:0] op2_reg;
    logic [4:0]        shamt_reg;
    logic [2:0]        select_reg;
    logic              id_reg;

    // Grant and next-state logic
    always_comb begin
        any_valid  = req0_valid | req1_valid;
        grant_id   = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ptr;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
        // Readies are forced low while reset is held, even though state
        // already reads IDLE at that point.
        handshake  = (state == IDLE) && any_valid && !reset;
        req0_ready = handshake && !grant_id;
        req1_ready = handshake && grant_id;

        state_next = state;
        case (state)
            IDLE:    if (any_valid)  state_next = EXEC;
            EXEC:                    state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand capture on request handshake, result capture in EXEC
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr         <= 1'b0;
            op1_reg     <= '0;
            op2_reg     <= '0;
            shamt_reg   <= '0;
            select_reg  <= '0;
            id_reg      <= 1'b0;
            resp_id     <= 1'b0;
            resp_result <= '0;
            resp_err    <= 1'b0;
        end else begin
            if (handshake) begin
                // Last winner becomes lowest priority
                ptr        <= ~grant_id;
                id_reg     <= grant_id;
                op1_reg    <= grant_id ? req1_op1    : req0_op1;
                op2_reg    <= grant_id ? req1_op2    : req0_op2;
                shamt_reg  <= grant_id ? req1_shamt  : req0_shamt;
                select_reg <= grant_id ? req1_select : req0_select;
            end
            if (state == EXEC) begin
                resp_id <= id_reg;
                // Selects 110/111 leave the ALU output undriven; never sample it
                if (select_reg[2:1] == 2'b11) begin
                    resp_err    <= 1'b1;
                    resp_result <= '0;
                end else begin
                    resp_err    <= 1'b0;
                    resp_result <= alu_result;
                end
            end
        end
    end

    assign resp_valid   = (state == RESP);
    assign alu_operand1 = op1_reg;
    assign alu_operand2 = op2_reg;
    assign alu_shamt    = shamt_reg;
    assign alu_select   = select_reg;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_arbiter
//  Purpose  : Self-checking bench for alu_arbiter. Contains a behavioural
//             model of the external combinational ALU, a table of single
//             transactions, and hand-written multi-cycle sequences
//             (alternation, backpressure, reset during EXEC).
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
    logic [4:0]  req0_shamt, req1_shamt;
    logic [2:0]  req0_select, req1_select;
    logic        resp_valid, resp_ready, resp_id, resp_err;
    logic [31:0] resp_result;
    logic [31:0] alu_operand1, alu_operand2, alu_result;
    logic [4:0]  alu_shamt;
    logic [2:0]  alu_select;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_op1     (req0_op1),
        .req0_op2     (req0_op2),
        .req0_shamt   (req0_shamt),
        .req0_select  (req0_select),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_op1     (req1_op1),
        .req1_op2     (req1_op2),
        .req1_shamt   (req1_shamt),
        .req1_select  (req1_select),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_id      (resp_id),
        .resp_result  (resp_result),
        .resp_err     (resp_err),
        .alu_operand1 (alu_operand1),
        .alu_operand2 (alu_operand2),
        .alu_shamt    (alu_shamt),
        .alu_select   (alu_select),
        .alu_result   (alu_result)
    );

    // External ALU model; illegal codes return a poison value that must
    // never reach resp_result.
    always_comb begin
        case (alu_select)
            3'b000:  alu_result = alu_operand1 + alu_operand2;
            3'b001:  alu_result = alu_operand1 - alu_operand2;
            3'b010:  alu_result = alu_operand1 & alu_operand2;
            3'b011:  alu_result = alu_operand1 | alu_operand2;
            3'b100:  alu_result = alu_operand1 << alu_shamt;
            3'b101:  alu_result = alu_operand1 >> alu_shamt;
            default: alu_result = 32'hDEADBEEF;
        endcase
    end

    typedef struct {
        logic        v0;
        logic        v1;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [4:0]  s0;
        logic [2:0]  f0;
        logic [31:0] a1;
        logic [31:0] b1;
        logic [4:0]  s1;
        logic [2:0]  f1;
        int          eid;
        logic [31:0] eres;
        logic        eerr;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1. Returns at posedge+1 just after the handshake
    // edge with the granted id, or -1 if no grant within the budget.
    task automatic wait_grant(output int id);
        id = -1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req0_ready && req1_ready) id = 2;
            else if (req0_ready)          id = 0;
            else if (req1_ready)          id = 1;
            @(posedge clk); #1;
            if (id != -1) break;
        end
    endtask

    // Called one cycle after the handshake edge (state EXEC). Checks the ALU
    // drive, then the response one edge later.
    task automatic check_exec_resp(input string name, input int eid,
                                   input logic [31:0] ea, input logic [31:0] eb,
                                   input logic [4:0] es, input logic [2:0] ef,
                                   input logic [31:0] eres, input logic eerr);
        chk({name, "_exec_valid"}, 32'(resp_valid), 32'd0);
        chk({name, "_alu_op1"},    alu_operand1, ea);
        chk({name, "_alu_op2"},    alu_operand2, eb);
        chk({name, "_alu_shamt"},  32'(alu_shamt), 32'(es));
        chk({name, "_alu_sel"},    32'(alu_select), 32'(ef));
        @(posedge clk); #1;
        chk({name, "_resp_valid"}, 32'(resp_valid), 32'd1);
        chk({name, "_resp_id"},    32'(resp_id), 32'(eid));
        chk({name, "_resp_result"}, resp_result, eres);
        chk({name, "_resp_err"},   32'(resp_err), 32'(eerr));
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gid;

        vecs[0] = '{1'b1, 1'b0, 32'd5, 32'd7, 5'd0, 3'b000, 32'd0, 32'd0, 5'd0, 3'b000, 0, 32'd12, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'd0, 32'd0, 5'd0, 3'b000, 32'h1234, 32'h5678, 5'd0, 3'b110, 1, 32'd0, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 32'd1, 32'd0, 5'd31, 3'b100, 32'd0, 32'd0, 5'd0, 3'b000, 0, 32'h80000000, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 32'd0, 32'd0, 5'd0, 3'b000, 32'h80000000, 32'd0, 5'd31, 3'b101, 1, 32'd1, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 3'b010, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 3'b011, 0, 32'h00F000F0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 3'b010, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 3'b011, 1, 32'hFFF0FFF0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 32'd0, 32'd0, 5'd0, 3'b000, 32'd7, 32'd9, 5'd3, 3'b111, 1, 32'd0, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 32'd3, 32'd5, 5'd0, 3'b001, 32'd0, 32'd0, 5'd0, 3'b000, 0, 32'hFFFFFFFE, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'd1, 5'd0, 3'b000, 32'd0, 32'd0, 5'd0, 3'b000, 0, 32'd0, 1'b0};
        vecs[9] = '{1'b1, 1'b1, 32'd1, 32'd1, 5'd0, 3'b000, 32'hF, 32'd0, 5'd4, 3'b100, 1, 32'hF0, 1'b0};

        reset = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_op1 = 32'hAAAA5555; req0_op2 = 32'h1; req0_shamt = 5'd3; req0_select = 3'b001;
        req1_op1 = 32'h5555AAAA; req1_op2 = 32'h2; req1_shamt = 5'd4; req1_select = 3'b010;
        resp_ready = 1'b1;

        // Reset state, with both requests pending
        repeat (2) @(posedge clk);
        #1;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_id",    32'(resp_id), 32'd0);
        chk("rst_resp_result", resp_result, 32'd0);
        chk("rst_resp_err",   32'(resp_err), 32'd0);
        chk("rst_alu_op1",    alu_operand1, 32'd0);
        chk("rst_alu_op2",    alu_operand2, 32'd0);
        chk("rst_alu_shamt",  32'(alu_shamt), 32'd0);
        chk("rst_alu_sel",    32'(alu_select), 32'd0);
        chk("rst_req0_ready", 32'(req0_ready), 32'd0);
        chk("rst_req1_ready", 32'(req1_ready), 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;

        // Table of single transactions (pointer state carries between rows)
        for (int i = 0; i < 10; i++) begin
            req0_valid = vecs[i].v0; req1_valid = vecs[i].v1;
            req0_op1 = vecs[i].a0; req0_op2 = vecs[i].b0;
            req0_shamt = vecs[i].s0; req0_select = vecs[i].f0;
            req1_op1 = vecs[i].a1; req1_op2 = vecs[i].b1;
            req1_shamt = vecs[i].s1; req1_select = vecs[i].f1;
            wait_grant(gid);
            chk($sformatf("v%0d_grant", i), 32'(gid), 32'(vecs[i].eid));
            req0_valid = 1'b0; req1_valid = 1'b0;
            if (vecs[i].eid == 0)
                check_exec_resp($sformatf("v%0d", i), 0, vecs[i].a0, vecs[i].b0,
                                vecs[i].s0, vecs[i].f0, vecs[i].eres, vecs[i].eerr);
            else
                check_exec_resp($sformatf("v%0d", i), 1, vecs[i].a1, vecs[i].b1,
                                vecs[i].s1, vecs[i].f1, vecs[i].eres, vecs[i].eerr);
            @(posedge clk); #1;
            chk($sformatf("v%0d_retired", i), 32'(resp_valid), 32'd0);
        end

        // Continuous dual requests: strict alternation 0,1,0,1
        pulse_reset();
        req0_op1 = 32'd10; req0_op2 = 32'd3; req0_shamt = 5'd0; req0_select = 3'b001;
        req1_op1 = 32'd0;  req1_op2 = 32'd1; req1_shamt = 5'd0; req1_select = 3'b001;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_grant(gid);
            chk($sformatf("alt%0d_grant", k), 32'(gid), 32'(k % 2));
            if (k % 2 == 0)
                check_exec_resp($sformatf("alt%0d", k), 0, 32'd10, 32'd3, 5'd0, 3'b001, 32'd7, 1'b0);
            else
                check_exec_resp($sformatf("alt%0d", k), 1, 32'd0, 32'd1, 5'd0, 3'b001, 32'hFFFFFFFF, 1'b0);
            @(posedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Backpressure: hold RESP 5 cycles with both requests pending
        pulse_reset();
        resp_ready = 1'b0;
        req0_op1 = 32'd1; req0_op2 = 32'd2; req0_select = 3'b000;
        req1_op1 = 32'd3; req1_op2 = 32'd4; req1_select = 3'b000;
        req0_valid = 1'b1; req1_valid = 1'b1;
        wait_grant(gid);
        chk("bp_grant0", 32'(gid), 32'd0);
        check_exec_resp("bp_first", 0, 32'd1, 32'd2, 5'd0, 3'b000, 32'd3, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("bp%0d_valid", c),  32'(resp_valid), 32'd1);
            chk($sformatf("bp%0d_result", c), resp_result, 32'd3);
            chk($sformatf("bp%0d_id", c),     32'(resp_id), 32'd0);
            chk($sformatf("bp%0d_readies", c), 32'({req1_ready, req0_ready}), 32'd0);
        end
        resp_ready = 1'b1;
        #1;
        chk("bp_ready_before_retire", 32'({req1_ready, req0_ready}), 32'd0);
        @(posedge clk); #1;
        chk("bp_retired", 32'(resp_valid), 32'd0);
        #1;
        chk("bp_next_grant", 32'({req1_ready, req0_ready}), 32'd2);
        #1;
        wait_grant(gid);
        chk("bp_grant1", 32'(gid), 32'd1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        check_exec_resp("bp_second", 1, 32'd3, 32'd4, 5'd0, 3'b000, 32'd7, 1'b0);
        @(posedge clk); #1;

        // Reset during EXEC: pointer had moved to 1, reset must restore 0
        pulse_reset();
        req0_op1 = 32'd2; req0_op2 = 32'd3; req0_select = 3'b000;
        req1_op1 = 32'd4; req1_op2 = 32'd4; req1_select = 3'b000;
        req0_valid = 1'b1; req1_valid = 1'b1;
        wait_grant(gid);
        chk("rx_grant_pre", 32'(gid), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("rx_resp_valid", 32'(resp_valid), 32'd0);
        chk("rx_alu_op1",    alu_operand1, 32'd0);
        chk("rx_alu_op2",    alu_operand2, 32'd0);
        chk("rx_alu_sel",    32'(alu_select), 32'd0);
        chk("rx_readies",    32'({req1_ready, req0_ready}), 32'd0);
        chk("rx_resp_result", resp_result, 32'd0);
        @(posedge clk); #1;
        chk("rx_no_resp", 32'(resp_valid), 32'd0);
        reset = 1'b0;
        wait_grant(gid);
        chk("rx_grant_post", 32'(gid), 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        check_exec_resp("rx_post", 0, 32'd2, 32'd3, 5'd0, 3'b000, 32'd5, 1'b0);
        @(posedge clk); #1;
        chk("rx_retired", 32'(resp_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
